// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the hardwired control unit.
//  - opcode localparams (IR[31:27])
//  - ALU operation codes (the ALU consumes the opcode value directly)
//  - control-state encoding and the per-class last execute step
package cpu_pkg;

    localparam logic [4:0] OP_LDW  = 5'd0;
    localparam logic [4:0] OP_LDI  = 5'd1;
    localparam logic [4:0] OP_ST   = 5'd2;
    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_SHR  = 5'd7;
    localparam logic [4:0] OP_SHL  = 5'd8;
    localparam logic [4:0] OP_ROR  = 5'd9;
    localparam logic [4:0] OP_ROL  = 5'd10;
    localparam logic [4:0] OP_ADDI = 5'd11;
    localparam logic [4:0] OP_ANDI = 5'd12;
    localparam logic [4:0] OP_ORI  = 5'd13;
    localparam logic [4:0] OP_MUL  = 5'd14;
    localparam logic [4:0] OP_DIV  = 5'd15;
    localparam logic [4:0] OP_NEG  = 5'd16;
    localparam logic [4:0] OP_NOT  = 5'd17;
    localparam logic [4:0] OP_BR   = 5'd18;
    localparam logic [4:0] OP_JR   = 5'd19;
    localparam logic [4:0] OP_JAL  = 5'd20;
    localparam logic [4:0] OP_IN   = 5'd21;
    localparam logic [4:0] OP_OUT  = 5'd22;
    localparam logic [4:0] OP_MFHI = 5'd23;
    localparam logic [4:0] OP_MFLO = 5'd24;
    localparam logic [4:0] OP_NOP  = 5'd25;
    localparam logic [4:0] OP_HALT = 5'd26;

    // ALU shares the opcode encoding; only ADD is forced for address math.
    localparam logic [4:0] ALU_ADD = OP_ADD;

    typedef enum logic [3:0] {
        S_IDLE, T0, T1, T2, T3, T4, T5, T6, T7, S_HALT
    } state_t;

    // Final execute step of each opcode class; it returns to T0 afterwards.
    function automatic state_t last_exec(input logic [4:0] opc);
        case (opc)
            OP_LDW, OP_ST:                         return T7;
            OP_MUL, OP_DIV, OP_BR:                 return T6;
            OP_NEG, OP_NOT, OP_JAL:                return T4;
            OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO: return T3;
            default:                               return T5;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Moore control unit for the DataPath.
//  Fetch T0..T2, execute T3..T7 per opcode class, HALT parks until clear.
// Ports:
//  Clock, clear (async active-low), IR[31:0] (opcode IR[31:27]), CON_FF
//  bus drivers: PCout Zlowout Zhighout HIout LOout MDRout In_Portout Cout Baout Rout
//  loads: MARin PCin MDRin IRin Yin Zin_low Zin_high HIin LOin r_in ConIn outPortenable
//  selects Gra Grb Grc; IncPC Read Write; operation[4:0]; Run
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic        Clock,
    input  logic        clear,
    input  logic [31:0] IR,
    input  logic        CON_FF,
    output logic PCout, Zlowout, Zhighout, HIout, LOout, MDRout, In_Portout, Cout, Baout, Rout,
    output logic MARin, PCin, MDRin, IRin, Yin, Zin_low, Zin_high, HIin, LOin, r_in, ConIn,
    output logic outPortenable,
    output logic Gra, Grb, Grc,
    output logic IncPC, Read, Write,
    output logic [4:0] operation,
    output logic Run
);

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    state_t        state_q, state_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic [4:0]    opc;
    logic          mem_state, mem_done;

    assign opc = IR[31:27];

    // States that hold a memory strobe for MEM_LAT cycles.
    assign mem_state = (state_q == T1) ||
                       (state_q == T6 && opc == OP_LDW) ||
                       (state_q == T7 && opc == OP_ST);
    assign mem_done  = (wcnt_q == CW'(MEM_LAT - 1));

    // Counter only runs while parked in a memory state, so it is 0 on entry.
    assign wcnt_d = (mem_state && !mem_done) ? wcnt_q + 1'b1 : '0;

    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: state_d = T0;
            T0:     state_d = T1;
            T1:     if (mem_done) state_d = T2;
            T2: begin
                if (opc == OP_HALT)                    state_d = S_HALT;
                else if (opc == OP_NOP || opc > OP_HALT) state_d = T0;
                else                                   state_d = T3;
            end
            S_HALT: state_d = S_HALT;
            default: begin
                if (mem_state && !mem_done)      state_d = state_q;
                else if (state_q == last_exec(opc)) state_d = T0;
                else                             state_d = state_t'(state_q + 4'd1);
            end
        endcase
    end

    always_comb begin
        {PCout, Zlowout, Zhighout, HIout, LOout, MDRout, In_Portout, Cout, Baout, Rout} = '0;
        {MARin, PCin, MDRin, IRin, Yin, Zin_low, Zin_high, HIin, LOin, r_in, ConIn} = '0;
        outPortenable = 1'b0;
        {Gra, Grb, Grc, IncPC, Read, Write} = '0;
        operation = '0;
        Run = (state_q != S_IDLE) && (state_q != S_HALT);
        case (state_q)
            T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin_low = 1'b1; end
            // PC is written back only once even when the read is stretched.
            T1: begin Zlowout = 1'b1; PCin = (wcnt_q == '0); Read = 1'b1; MDRin = 1'b1; end
            T2: begin MDRout = 1'b1; IRin = 1'b1; end
            T3, T4, T5, T6, T7: begin
                case (opc)
                    OP_LDW, OP_LDI, OP_ST: begin
                        case (state_q)
                            T3: begin Grb = 1'b1; Baout = 1'b1; Yin = 1'b1; end
                            T4: begin Cout = 1'b1; operation = ALU_ADD; Zin_low = 1'b1; end
                            T5: begin
                                Zlowout = 1'b1;
                                if (opc == OP_LDI) begin Gra = 1'b1; r_in = 1'b1; end
                                else MARin = 1'b1;
                            end
                            T6: begin
                                MDRin = 1'b1;
                                if (opc == OP_LDW) Read = 1'b1;
                                else begin Gra = 1'b1; Rout = 1'b1; end
                            end
                            T7: begin
                                if (opc == OP_LDW) begin MDRout = 1'b1; Gra = 1'b1; r_in = 1'b1; end
                                else Write = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
                    OP_MUL, OP_DIV: begin
                        case (state_q)
                            T3: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                            T4: begin
                                Grc = 1'b1; Rout = 1'b1; operation = opc;
                                Zin_low = 1'b1; Zin_high = 1'b1;
                            end
                            T5: begin
                                Zlowout = 1'b1;
                                if (opc == OP_MUL || opc == OP_DIV) LOin = 1'b1;
                                else begin Gra = 1'b1; r_in = 1'b1; end
                            end
                            T6: begin Zhighout = 1'b1; HIin = 1'b1; end
                            default: ;
                        endcase
                    end
                    OP_NEG, OP_NOT: begin
                        if (state_q == T3) begin
                            Grb = 1'b1; Rout = 1'b1; operation = opc; Zin_low = 1'b1;
                        end else begin
                            Zlowout = 1'b1; Gra = 1'b1; r_in = 1'b1;
                        end
                    end
                    OP_ADDI, OP_ANDI, OP_ORI: begin
                        case (state_q)
                            T3: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                            T4: begin Cout = 1'b1; operation = opc; Zin_low = 1'b1; end
                            T5: begin Zlowout = 1'b1; Gra = 1'b1; r_in = 1'b1; end
                            default: ;
                        endcase
                    end
                    OP_BR: begin
                        case (state_q)
                            T3: begin Gra = 1'b1; Rout = 1'b1; ConIn = 1'b1; end
                            T4: begin PCout = 1'b1; Yin = 1'b1; end
                            T5: begin Cout = 1'b1; operation = ALU_ADD; Zin_low = 1'b1; end
                            T6: begin Zlowout = 1'b1; PCin = CON_FF; end
                            default: ;
                        endcase
                    end
                    OP_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                    OP_JAL: begin
                        if (state_q == T3) begin PCout = 1'b1; Grb = 1'b1; r_in = 1'b1; end
                        else begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                    end
                    OP_MFHI: begin HIout = 1'b1; Gra = 1'b1; r_in = 1'b1; end
                    OP_MFLO: begin LOout = 1'b1; Gra = 1'b1; r_in = 1'b1; end
                    OP_IN:   begin In_Portout = 1'b1; Gra = 1'b1; r_in = 1'b1; end
                    OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; outPortenable = 1'b1; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  logic Clock = 1'b0;
  logic clear = 1'b0;
  logic [31:0] IR = 32'h0;
  logic CON_FF = 1'b0;

  always #5 Clock = ~Clock;

  wire [33:0] obs1, obs3;

  localparam logic [33:0] PCOUT = 34'd1 << 0,  ZLOWOUT = 34'd1 << 1,  ZHIGHOUT = 34'd1 << 2;
  localparam logic [33:0] HIOUT = 34'd1 << 3,  LOOUT   = 34'd1 << 4,  MDROUT   = 34'd1 << 5;
  localparam logic [33:0] INPO  = 34'd1 << 6,  COUT    = 34'd1 << 7,  BAOUT    = 34'd1 << 8;
  localparam logic [33:0] ROUT  = 34'd1 << 9,  MARIN   = 34'd1 << 10, PCIN     = 34'd1 << 11;
  localparam logic [33:0] MDRIN = 34'd1 << 12, IRIN    = 34'd1 << 13, YIN      = 34'd1 << 14;
  localparam logic [33:0] ZINL  = 34'd1 << 15, ZINH    = 34'd1 << 16, HIIN     = 34'd1 << 17;
  localparam logic [33:0] LOIN  = 34'd1 << 18, RIN     = 34'd1 << 19, CONIN    = 34'd1 << 20;
  localparam logic [33:0] OUTPE = 34'd1 << 21, GRA     = 34'd1 << 22, GRB      = 34'd1 << 23;
  localparam logic [33:0] GRC   = 34'd1 << 24, INCPC   = 34'd1 << 25, READ     = 34'd1 << 26;
  localparam logic [33:0] WRITE = 34'd1 << 27, RUN     = 34'd1 << 28;

  localparam logic [33:0] F0 = PCOUT | MARIN | INCPC | ZINL | RUN;
  localparam logic [33:0] F1 = ZLOWOUT | PCIN | READ | MDRIN | RUN;
  localparam logic [33:0] F1W = ZLOWOUT | READ | MDRIN | RUN;
  localparam logic [33:0] F2 = MDROUT | IRIN | RUN;

  function automatic logic [33:0] OP(input logic [4:0] o);
    return {o, 29'b0};
  endfunction

  control_sequencer #(.MEM_LAT(1)) u_l1 (
    .Clock(Clock), .clear(clear), .IR(IR), .CON_FF(CON_FF),
    .PCout(obs1[0]), .Zlowout(obs1[1]), .Zhighout(obs1[2]), .HIout(obs1[3]),
    .LOout(obs1[4]), .MDRout(obs1[5]), .In_Portout(obs1[6]), .Cout(obs1[7]),
    .Baout(obs1[8]), .Rout(obs1[9]), .MARin(obs1[10]), .PCin(obs1[11]),
    .MDRin(obs1[12]), .IRin(obs1[13]), .Yin(obs1[14]), .Zin_low(obs1[15]),
    .Zin_high(obs1[16]), .HIin(obs1[17]), .LOin(obs1[18]), .r_in(obs1[19]),
    .ConIn(obs1[20]), .outPortenable(obs1[21]), .Gra(obs1[22]), .Grb(obs1[23]),
    .Grc(obs1[24]), .IncPC(obs1[25]), .Read(obs1[26]), .Write(obs1[27]),
    .operation(obs1[33:29]), .Run(obs1[28]));

  control_sequencer #(.MEM_LAT(3)) u_l3 (
    .Clock(Clock), .clear(clear), .IR(IR), .CON_FF(CON_FF),
    .PCout(obs3[0]), .Zlowout(obs3[1]), .Zhighout(obs3[2]), .HIout(obs3[3]),
    .LOout(obs3[4]), .MDRout(obs3[5]), .In_Portout(obs3[6]), .Cout(obs3[7]),
    .Baout(obs3[8]), .Rout(obs3[9]), .MARin(obs3[10]), .PCin(obs3[11]),
    .MDRin(obs3[12]), .IRin(obs3[13]), .Yin(obs3[14]), .Zin_low(obs3[15]),
    .Zin_high(obs3[16]), .HIin(obs3[17]), .LOin(obs3[18]), .r_in(obs3[19]),
    .ConIn(obs3[20]), .outPortenable(obs3[21]), .Gra(obs3[22]), .Grb(obs3[23]),
    .Grc(obs3[24]), .IncPC(obs3[25]), .Read(obs3[26]), .Write(obs3[27]),
    .operation(obs3[33:29]), .Run(obs3[28]));

  typedef struct {
    logic [4:0]  opc;
    logic        con;
    logic [33:0] exp;
  } vec_t;

  vec_t tbl[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [33:0] act, input logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [4:0] opc, input logic con, input logic [33:0] exp);
    vec_t v;
    v.opc = opc; v.con = con; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic run_tbl(input string nm, input bit use3);
    for (int i = 0; i < tbl.size(); i++) begin
      IR = {tbl[i].opc, 27'h0800055};
      CON_FF = tbl[i].con;
      #1;
      chk($sformatf("%s[%0d]", nm, i), use3 ? obs3 : obs1, tbl[i].exp);
      @(negedge Clock);
    end
    tbl.delete();
  endtask

  task automatic do_reset();
    @(negedge Clock);
    clear = 1'b0;
    #1;
    chk("rst_async_l1", obs1, '0);
    chk("rst_async_l3", obs3, '0);
    repeat (3) @(negedge Clock);
    chk("rst_hold_l1", obs1, '0);
    clear = 1'b1;
    @(negedge Clock);
  endtask

  initial begin
    do_reset();

    add(5'd0, 0, F0); add(5'd0, 0, F1); add(5'd0, 0, F2);
    add(5'd0, 0, GRB | BAOUT | YIN | RUN);
    add(5'd0, 0, COUT | OP(5'd3) | ZINL | RUN);
    add(5'd0, 0, ZLOWOUT | MARIN | RUN);
    add(5'd0, 0, READ | MDRIN | RUN);
    add(5'd0, 0, MDROUT | GRA | RIN | RUN);
    add(5'd4, 0, F0); add(5'd4, 0, F1); add(5'd4, 0, F2);
    add(5'd4, 0, GRB | ROUT | YIN | RUN);
    add(5'd4, 0, GRC | ROUT | OP(5'd4) | ZINL | ZINH | RUN);
    add(5'd4, 0, ZLOWOUT | GRA | RIN | RUN);
    for (int k = 0; k < 2; k++) begin
      add(5'd18, k[0], F0); add(5'd18, k[0], F1); add(5'd18, k[0], F2);
      add(5'd18, k[0], GRA | ROUT | CONIN | RUN);
      add(5'd18, k[0], PCOUT | YIN | RUN);
      add(5'd18, k[0], COUT | OP(5'd3) | ZINL | RUN);
      add(5'd18, k[0], ZLOWOUT | (k == 1 ? PCIN : 34'd0) | RUN);
    end
    add(5'd14, 0, F0); add(5'd14, 0, F1); add(5'd14, 0, F2);
    add(5'd14, 0, GRB | ROUT | YIN | RUN);
    add(5'd14, 0, GRC | ROUT | OP(5'd14) | ZINL | ZINH | RUN);
    add(5'd14, 0, ZLOWOUT | LOIN | RUN);
    add(5'd14, 0, ZHIGHOUT | HIIN | RUN);
    add(5'd16, 0, F0); add(5'd16, 0, F1); add(5'd16, 0, F2);
    add(5'd16, 0, GRB | ROUT | OP(5'd16) | ZINL | RUN);
    add(5'd16, 0, ZLOWOUT | GRA | RIN | RUN);
    add(5'd11, 0, F0); add(5'd11, 0, F1); add(5'd11, 0, F2);
    add(5'd11, 0, GRB | ROUT | YIN | RUN);
    add(5'd11, 0, COUT | OP(5'd11) | ZINL | RUN);
    add(5'd11, 0, ZLOWOUT | GRA | RIN | RUN);
    add(5'd20, 0, F0); add(5'd20, 0, F1); add(5'd20, 0, F2);
    add(5'd20, 0, PCOUT | GRB | RIN | RUN);
    add(5'd20, 0, GRA | ROUT | PCIN | RUN);
    add(5'd24, 0, F0); add(5'd24, 0, F1); add(5'd24, 0, F2);
    add(5'd24, 0, LOOUT | GRA | RIN | RUN);
    add(5'd22, 0, F0); add(5'd22, 0, F1); add(5'd22, 0, F2);
    add(5'd22, 0, GRA | ROUT | OUTPE | RUN);
    add(5'd26, 0, F0); add(5'd26, 0, F1); add(5'd26, 0, F2);
    add(5'd26, 0, 34'd0);
    run_tbl("main", 1'b0);

    begin
      int bad = 0;
      for (int c = 0; c < 20; c++) begin
        if (obs1 !== 34'd0) bad++;
        @(negedge Clock);
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL halt_frozen got=%0d nonzero cycles want=0", bad);
      end
    end
    do_reset();
    chk("halt_restart_T0", obs1, F0);

    do_reset();
    add(5'd2, 0, F0); add(5'd2, 0, F1); add(5'd2, 0, F1W); add(5'd2, 0, F1W);
    add(5'd2, 0, F2);
    add(5'd2, 0, GRB | BAOUT | YIN | RUN);
    add(5'd2, 0, COUT | OP(5'd3) | ZINL | RUN);
    add(5'd2, 0, ZLOWOUT | MARIN | RUN);
    add(5'd2, 0, GRA | ROUT | MDRIN | RUN);
    add(5'd2, 0, WRITE | RUN); add(5'd2, 0, WRITE | RUN); add(5'd2, 0, WRITE | RUN);
    add(5'd2, 0, F0);
    run_tbl("st_lat3", 1'b1);

    do_reset();
    IR = 32'h00800055;
    repeat (6) @(negedge Clock);
    chk("ld_T6", obs1, READ | MDRIN | RUN);
    #2 clear = 1'b0;
    #1 chk("abort_async", obs1, '0);
    @(negedge Clock);
    clear = 1'b1;
    @(negedge Clock);
    chk("abort_restart_T0", obs1, F0);
    IR = 32'hF8000000;
    @(negedge Clock); chk("undef_T1", obs1, F1);
    @(negedge Clock); chk("undef_T2", obs1, F2);
    @(negedge Clock); chk("undef_back_T0", obs1, F0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
